// File: rtl/payload_engine_ctrl.sv
// payload_engine_ctrl: streams packet bytes into a parallel engine bank and reports per-packet matches.
// Optional packet/hit counters are built only when PAYLOAD_ENGINE_CTRL_STATS_EN is defined.
module payload_engine_ctrl #(
   parameter int NUM_ENG = 64,
   parameter int IDX_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         s_data,
   input  logic               s_valid,
   input  logic               s_sof,
   input  logic               s_eof,
   output logic               s_ready,
   output logic [7:0]         eng_char,
   output logic               eng_char_vld,
   output logic               eng_en,
   output logic               eng_sod,
   input  logic [NUM_ENG-1:0] eng_match,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [NUM_ENG-1:0] m_match_vec,
   output logic               m_any,
   output logic [IDX_W-1:0]   m_first_idx,
   output logic [31:0]        stat_pkts,
   output logic [31:0]        stat_hits
);
   typedef enum logic [2:0] {IDLE, SOD, RUN, DRAIN, REPORT} state_t;

   state_t             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [7:0]         eng_char_q, eng_char_d;
   logic               eng_char_vld_q, eng_char_vld_d;
   logic               eng_en_q, eng_en_d;
   logic               eng_sod_q, eng_sod_d;
   logic               m_valid_q, m_valid_d;
   logic [NUM_ENG-1:0] m_match_vec_q, m_match_vec_d;
   logic               m_any_q, m_any_d;
   logic [IDX_W-1:0]   m_first_idx_q, m_first_idx_d;
   logic [IDX_W-1:0]   first_idx;
   logic               hs;

   assign hs = m_valid_q && m_ready;

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      first_idx = '0;
      for (int i = NUM_ENG - 1; i >= 0; i--) if (eng_match[i]) first_idx = IDX_W'(i);
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      s_ready        = 1'b0;
      eng_char_d     = eng_char_q;
      eng_char_vld_d = 1'b0;
      eng_en_d       = 1'b0;
      eng_sod_d      = 1'b0;
      m_valid_d      = m_valid_q;
      m_match_vec_d  = m_match_vec_q;
      m_any_d        = m_any_q;
      m_first_idx_d  = m_first_idx_q;
      case (state_q)
         IDLE: begin
            s_ready = !s_sof;
            if (s_valid && s_sof) state_d = SOD;
         end
         SOD: begin
            eng_sod_d = 1'b1;
            state_d   = RUN;
         end
         RUN: begin
            s_ready = 1'b1;
            if (s_valid) begin
               eng_char_d     = s_data;
               eng_char_vld_d = 1'b1;
               eng_en_d       = 1'b1;
               if (s_eof) begin
                  state_d = DRAIN;
                  cnt_d   = 2'd0;
               end
            end
         end
         DRAIN: begin
            // One flush step with no character lets sticky end states latch.
            eng_en_d = (cnt_q == 2'd0);
            cnt_d    = cnt_q + 2'd1;
            if (cnt_q == 2'd2) begin
               state_d       = REPORT;
               m_valid_d     = 1'b1;
               m_match_vec_d = eng_match;
               m_any_d       = |eng_match;
               m_first_idx_d = first_idx;
            end
         end
         REPORT: begin
            if (hs) begin
               m_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         eng_char_q     <= '0;
         eng_char_vld_q <= 1'b0;
         eng_en_q       <= 1'b0;
         eng_sod_q      <= 1'b1;
         m_valid_q      <= 1'b0;
         m_match_vec_q  <= '0;
         m_any_q        <= 1'b0;
         m_first_idx_q  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         eng_char_q     <= eng_char_d;
         eng_char_vld_q <= eng_char_vld_d;
         eng_en_q       <= eng_en_d;
         eng_sod_q      <= eng_sod_d;
         m_valid_q      <= m_valid_d;
         m_match_vec_q  <= m_match_vec_d;
         m_any_q        <= m_any_d;
         m_first_idx_q  <= m_first_idx_d;
      end
   end

   assign eng_char     = eng_char_q;
   assign eng_char_vld = eng_char_vld_q;
   assign eng_en       = eng_en_q;
   assign eng_sod      = eng_sod_q;
   assign m_valid      = m_valid_q;
   assign m_match_vec  = m_match_vec_q;
   assign m_any        = m_any_q;
   assign m_first_idx  = m_first_idx_q;

`ifdef PAYLOAD_ENGINE_CTRL_STATS_EN
   logic [31:0] stat_pkts_q, stat_hits_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_pkts_q <= '0;
         stat_hits_q <= '0;
      end else if (hs) begin
         if (stat_pkts_q != '1) stat_pkts_q <= stat_pkts_q + 32'd1;
         if (m_any_q && stat_hits_q != '1) stat_hits_q <= stat_hits_q + 32'd1;
      end
   end

   assign stat_pkts = stat_pkts_q;
   assign stat_hits = stat_hits_q;
`else
   assign stat_pkts = '0;
   assign stat_hits = '0;
`endif
endmodule

// File: tb/tb_payload_engine_ctrl.sv
// tb_payload_engine_ctrl: table-driven packets with a result scoreboard plus reset/idle corner sequences.
module tb_payload_engine_ctrl;
   localparam int NUM_ENG = 64;
   localparam int IDX_W   = 6;
`ifdef PAYLOAD_ENGINE_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic [7:0]         s_data;
   logic               s_valid, s_sof, s_eof, s_ready;
   logic [7:0]         eng_char;
   logic               eng_char_vld, eng_en, eng_sod;
   logic [NUM_ENG-1:0] eng_match;
   logic               m_valid, m_ready, m_any;
   logic [NUM_ENG-1:0] m_match_vec;
   logic [IDX_W-1:0]   m_first_idx;
   logic [31:0]        stat_pkts, stat_hits;

   payload_engine_ctrl #(.NUM_ENG(NUM_ENG), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_eof(s_eof),
      .s_ready(s_ready), .eng_char(eng_char), .eng_char_vld(eng_char_vld), .eng_en(eng_en),
      .eng_sod(eng_sod), .eng_match(eng_match), .m_valid(m_valid), .m_ready(m_ready),
      .m_match_vec(m_match_vec), .m_any(m_any), .m_first_idx(m_first_idx),
      .stat_pkts(stat_pkts), .stat_hits(stat_hits)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bytes;
      int          len;
      logic [63:0] mvec;
      logic        any;
      logic [5:0]  idx;
      int          wait_c;
   } vec_t;
   typedef struct {
      int          cyc;
      logic [63:0] vec;
      logic        any;
      logic [5:0]  idx;
   } exp_t;
   typedef struct {
      int         cyc;
      logic       vld;
      logic [7:0] ch;
   } ev_t;

   exp_t        sb[$];
   ev_t         elog[$];
   int          sod_log[$];
   int          errors = 0, checks = 0, cyc = 0;
   int          acc_cyc[4];
   bit          mv_prev = 0, mv_seen = 0;
   logic [31:0] exp_pkts = 0, exp_hits = 0;
   vec_t        vecs[5];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && eng_en) elog.push_back('{cyc, eng_char_vld, eng_char});
      if (rst_n && eng_sod) sod_log.push_back(cyc);
      if (m_valid && !mv_prev) begin
         mv_seen = 1;
         if (sb.size() == 0) chk("unexpected_m_valid", 1, 0);
         else begin
            e = sb.pop_front();
            chk("m_valid_cycle", cyc, e.cyc);
            chk("m_match_vec", m_match_vec, e.vec);
            chk("m_any", m_any, e.any);
            chk("m_first_idx", m_first_idx, e.idx);
         end
      end
      mv_prev = m_valid;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic do_reset();
      rst_n = 0;
      s_valid = 0; s_sof = 0; s_eof = 0; m_ready = 0; eng_match = '0;
      @(posedge clk); #1;
      exp_pkts = 0; exp_hits = 0; sb.delete();
      @(negedge clk);
      chk("rst_eng_sod", eng_sod, 1);
      chk("rst_eng_en", eng_en, 0);
      chk("rst_eng_char_vld", eng_char_vld, 0);
      chk("rst_eng_char", eng_char, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_match_vec", m_match_vec, 0);
      chk("rst_m_any", m_any, 0);
      chk("rst_m_first_idx", m_first_idx, 0);
      chk("rst_stat_pkts", stat_pkts, 0);
      chk("rst_stat_hits", stat_hits, 0);
      chk("rst_idle_ready", s_ready, 1);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_eng_sod", eng_sod, 0);
      @(posedge clk); #1;
   endtask

   task automatic drive_bytes(input logic [31:0] b, input int len, input bit with_eof);
      for (int i = 0; i < len; i++) begin
         bit got;
         got = 0;
         s_valid = 1; s_data = b[8*i +: 8]; s_sof = (i == 0); s_eof = with_eof && (i == len - 1);
         for (int g = 0; g < 10 && !got; g++) begin
            @(negedge clk);
            if (s_ready) begin
               got = 1;
               acc_cyc[i] = cyc;
            end
            @(posedge clk); #1;
         end
         chk("byte_accept", got, 1);
      end
      s_valid = 0; s_sof = 0; s_eof = 0;
   endtask

   task automatic run_pkt(input vec_t v);
      int t;
      elog.delete(); sod_log.delete(); mv_seen = 0;
      drive_bytes(v.bytes, v.len, 1);
      t = acc_cyc[v.len-1];
      sb.push_back('{t + 4, v.mvec, v.any, v.idx});
      repeat (2) begin @(posedge clk); #1; end
      eng_match = v.mvec;
      @(posedge clk); #1;
      eng_match = '0;
      for (int k = 0; k < 10 && !mv_seen; k++) begin @(posedge clk); #1; end
      chk("m_valid_seen", mv_seen, 1);
      if (!mv_seen) sb.delete();
      s_valid = 1; s_sof = 0; s_data = 8'hEE;
      repeat (v.wait_c) begin
         @(negedge clk);
         chk("hold_m_valid", m_valid, 1);
         chk("hold_m_match_vec", m_match_vec, v.mvec);
         chk("hold_m_any", m_any, v.any);
         chk("hold_m_first_idx", m_first_idx, v.idx);
         chk("hold_s_ready", s_ready, 0);
         @(posedge clk); #1;
      end
      m_ready = 1;
      @(negedge clk);
      chk("hs_m_valid", m_valid, 1);
      if (STATS) begin
         if (exp_pkts != '1) exp_pkts++;
         if (v.any && exp_hits != '1) exp_hits++;
      end
      @(posedge clk); #1;
      m_ready = 0;
      @(negedge clk);
      chk("post_hs_m_valid", m_valid, 0);
      chk("post_hs_idle_ready", s_ready, 1);
      chk("stat_pkts", stat_pkts, exp_pkts);
      chk("stat_hits", stat_hits, exp_hits);
      @(posedge clk); #1;
      s_valid = 0;
      chk("sod_pulses", sod_log.size(), 1);
      if (sod_log.size() > 0) chk("sod_cycle", sod_log[0], acc_cyc[0]);
      chk("eng_en_pulses", elog.size(), v.len + 1);
      for (int i = 0; i < elog.size() && i <= v.len; i++) begin
         chk("eng_en_cycle", elog[i].cyc, (i < v.len) ? acc_cyc[i] + 1 : t + 2);
         chk("eng_char_vld", elog[i].vld, i < v.len);
         if (i < v.len) chk("eng_char", elog[i].ch, v.bytes[8*i +: 8]);
      end
   endtask

   task automatic idle_junk(input int n);
      elog.delete(); sod_log.delete(); mv_seen = 0;
      for (int i = 0; i < n; i++) begin
         s_valid = 1; s_sof = 0; s_eof = (i == n - 1); s_data = 8'h10 + 8'(i);
         @(negedge clk);
         chk("idle_ready", s_ready, 1);
         @(posedge clk); #1;
      end
      s_valid = 0; s_eof = 0;
      repeat (6) begin @(posedge clk); #1; end
      chk("idle_no_eng_en", elog.size(), 0);
      chk("idle_no_sod", sod_log.size(), 0);
      chk("idle_no_m_valid", mv_seen, 0);
   endtask

   initial begin
      rst_n = 0; s_data = 0; s_valid = 0; s_sof = 0; s_eof = 0; m_ready = 0; eng_match = '0;
      vecs[0] = '{32'h0000_4241, 2, 64'h1, 1'b1, 6'd0, 0};
      vecs[1] = '{32'h0000_004F, 1, 64'h0, 1'b0, 6'd0, 1};
      vecs[2] = '{32'h005A_5958, 3, 64'h0000_0100_0000_0020, 1'b1, 6'd5, 10};
      vecs[3] = '{32'h3433_3231, 4, 64'h8000_0000_0000_0000, 1'b1, 6'd63, 2};
      vecs[4] = '{32'h0000_FF00, 2, 64'h0000_0000_0001_0000, 1'b1, 6'd16, 0};
      do_reset();
      for (int i = 0; i < 5; i++) run_pkt(vecs[i]);
      idle_junk(5);
      drive_bytes(32'h0063_6261, 3, 0);
      do_reset();
      idle_junk(2);
      run_pkt(vecs[0]);
`ifdef PAYLOAD_ENGINE_CTRL_STATS_EN
      force dut.stat_pkts_q = 32'hFFFF_FFFE;
      force dut.stat_hits_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.stat_pkts_q;
      release dut.stat_hits_q;
      exp_pkts = 32'hFFFF_FFFE;
      exp_hits = 32'hFFFF_FFFE;
      @(posedge clk); #1;
`endif
      run_pkt(vecs[0]);
      run_pkt(vecs[2]);
      chk("sat_stat_pkts", stat_pkts, STATS ? 32'hFFFF_FFFF : 32'h0);
      chk("sat_stat_hits", stat_hits, STATS ? 32'hFFFF_FFFF : 32'h0);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/payload_engine_ctrl.md
PAYLOAD_ENGINE_CTRL -- requirements
Module: payload_engine_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENG, default 64, number of engine match outputs sequenced in parallel.
REQ-002 SHALL have parameter IDX_W, default 6, width of first-match index; SHALL equal clog2(NUM_ENG).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port s_data  input  8  payload byte.
REQ-006 SHALL have ports s_valid, s_sof, s_eof  input  1 each  byte valid, first byte of packet, last byte of packet.
REQ-007 SHALL have port s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-008 SHALL have port eng_char  output  8  byte to the engine-bank character decoder.
REQ-009 SHALL have port eng_char_vld  output  1  when 0, the decoder drives all in_* character lines low.
REQ-010 SHALL have ports eng_en, eng_sod  output  1 each  engine-bank en and sod (flop clear).
REQ-011 SHALL have port eng_match  input  NUM_ENG  engine-bank out bits.
REQ-012 SHALL have ports m_valid output 1, m_ready input 1  result handshake.
REQ-013 SHALL have ports m_match_vec output NUM_ENG, m_any output 1, m_first_idx output IDX_W  per-packet result.
REQ-014 SHALL have ports stat_pkts, stat_hits  output  32 each  packet and matching-packet counters.

Function
REQ-015 SHALL implement FSM states IDLE, SOD, RUN, DRAIN, REPORT.
REQ-016 IDLE: s_ready = !s_sof; s_valid && !s_sof bytes are consumed and discarded; s_valid && s_sof -> SOD, byte not consumed.
REQ-017 SOD: one cycle, s_ready=0, registered eng_sod=1 next cycle; -> RUN.
REQ-018 RUN: s_ready=1; accepted byte appears on eng_char with eng_en=1, eng_char_vld=1 exactly one cycle later; no accept -> eng_en=0 next cycle.
REQ-019 RUN: s_sof on an accepted byte SHALL be ignored (treated as data); accept with s_eof -> DRAIN.
REQ-020 Single-byte packet (s_sof && s_eof): SOD, then RUN accepts it and goes directly to DRAIN.
REQ-021 DRAIN: 3 cycles, s_ready=0; first cycle drives one flush step (registered eng_en=1, eng_char_vld=0) so sticky end states latch; captures eng_match into m_match_vec at end of third cycle; -> REPORT.
REQ-022 m_valid SHALL rise exactly 4 cycles after the eof-accept cycle T (high from T+4).
REQ-023 m_any = |m_match_vec; m_first_idx = lowest set bit index, 0 when m_any=0.
REQ-024 REPORT: m_valid and results held stable until m_valid && m_ready; then -> IDLE, m_valid=0 next cycle; s_ready=0 in REPORT.
REQ-025 eng_char, eng_char_vld, eng_en, eng_sod, m_* outputs SHALL all be registered.
REQ-026 stat_pkts increments on each REPORT handshake; stat_hits also when m_any=1; both saturate at 0xFFFFFFFF.

Reset
REQ-027 rst_n=0 at any edge (including mid-packet) SHALL force IDLE, eng_sod=1, eng_en=0, eng_char_vld=0, eng_char=0, m_valid=0, m_match_vec=0, m_any=0, m_first_idx=0, stat_pkts=0, stat_hits=0.
REQ-028 First cycle after reset release eng_sod=0; bytes of an interrupted packet without s_sof are dropped per REQ-016.

Configuration
REQ-029 Macro PAYLOAD_ENGINE_CTRL_STATS_EN defined: counters behave per REQ-026.
REQ-030 Macro not defined: stat_pkts, stat_hits ports present, tied to 0, no counter flops.

Verification
REQ-031 Packet "AB" (sof on A, eof on B), eng_match=0x1 from T+3 -> eng_sod pulse once, eng_en pulses with 0x41 then 0x42, flush pulse, m_valid at T+4, m_first_idx=0, m_any=1.
REQ-032 Single byte 0x4F sof+eof, eng_match=0 -> m_valid at T+4, m_any=0, m_first_idx=0, stat_pkts=1, stat_hits=0.
REQ-033 eng_match bits 5 and 40 set, m_ready low 10 cycles -> results stable, s_ready=0 throughout, IDLE after handshake, m_first_idx=5.
REQ-034 Bytes without s_sof in IDLE -> consumed, no eng_en, no eng_sod, no m_valid.
REQ-035 rst_n low in RUN after 3 bytes -> next cycle all outputs at REQ-027 values, next sof packet processes normally.
REQ-036 Stats preloaded near 0xFFFFFFFF (force), two hit packets -> both counters stick at 0xFFFFFFFF; macro undefined -> both read 0.
